// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one fetch at a time into a
// single-entry decode buffer, and drops wrong-path responses after a redirect.
module fetch_sequencer #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_next_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_e;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              vld_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] bpc_q;

  logic              issue;
  logic              consume;
  logic [ADDR_W-1:0] target_d;

  // A request goes out only when the buffer will be empty by the time the response lands.
  assign issue    = (state_q == REQ) && (!vld_q || out_ready);
  assign consume  = vld_q && out_ready;
  assign target_d = redirect_target & ALIGN_MASK;

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign out_valid   = vld_q;
  assign out_instr   = instr_q;
  assign out_pc      = bpc_q;
  assign out_next_pc = bpc_q + PC_STEP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      instr_q <= '0;
      bpc_q   <= RESET_PC;
    end else if (redirect_valid) begin
      // Redirect wins over every other event; an in-flight old-path fetch must be drained.
      pc_q  <= target_d;
      vld_q <= 1'b0;
      unique case (state_q)
        IDLE:    state_q <= REQ;
        REQ:     state_q <= (issue && imem_gnt) ? DISCARD : REQ;
        WAIT:    state_q <= imem_rvalid ? REQ : DISCARD;
        DISCARD: state_q <= imem_rvalid ? REQ : DISCARD;
        default: state_q <= IDLE;
      endcase
    end else begin
      if (consume) vld_q <= 1'b0;
      unique case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (issue && imem_gnt) state_q <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            vld_q   <= 1'b1;
            instr_q <= imem_rdata;
            bpc_q   <= pc_q;
            pc_q    <= pc_q + PC_STEP;
            state_q <= REQ;
          end
        end
        DISCARD: begin
          if (imem_rvalid) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected fetches are queued by the stimulus
// thread and popped by a monitor whenever decode consumes the output buffer.
module tb_fetch_sequencer;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_next_pc;

  fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_next_pc    (out_next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  int                lat   = 1;
  bit                stray = 1'b0;
  bit                pending;
  int                cnt;
  logic [ADDR_W-1:0] paddr;

  function automatic logic [DATA_W-1:0] instr_of(input logic [ADDR_W-1:0] a);
    return {16'hC0DE, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] pc);
    exp_q.push_back({pc, instr_of(pc)});
  endtask

  task automatic wait_buf(input logic [ADDR_W-1:0] pc, input int max_cyc);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #2;
      if (out_valid && out_pc == pc) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("wait_buf_%h", pc), {31'd0, got}, 32'd1);
  endtask

  task automatic wait_req(input int max_cyc);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #2;
      if (imem_req) begin
        got = 1'b1;
        break;
      end
    end
    check("wait_req", {31'd0, got}, 32'd1);
  endtask

  // Memory responder: records grants just before the edge, answers lat cycles later.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pending     = 1'b0;
    cnt         = 0;
    paddr       = '0;
    forever begin
      @(negedge clk); #1;
      imem_rvalid = 1'b0;
      if (!reset) begin
        pending = 1'b0;
      end else if (stray) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        stray       = 1'b0;
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instr_of(paddr);
          pending     = 1'b0;
        end
      end
      #3;
      if (reset && imem_req && imem_gnt) begin
        pending = 1'b1;
        cnt     = lat;
        paddr   = imem_addr;
      end
    end
  end

  // Monitor: every consumption must match the head of the expected queue.
  initial begin
    logic [ADDR_W+DATA_W-1:0] e;
    forever begin
      @(negedge clk); #3;
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_consume_pc", {16'd0, out_pc}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", {16'd0, out_pc}, {16'd0, e[ADDR_W+DATA_W-1:DATA_W]});
          check("out_instr", out_instr, e[DATA_W-1:0]);
          check("out_next_pc", {16'd0, out_next_pc},
                {16'd0, e[ADDR_W+DATA_W-1:DATA_W] + 16'd4});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b0;
    out_ready       = 1'b1;
    imem_gnt        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    #2;
    check("rst_imem_req",  {31'd0, imem_req},     32'd0);
    check("rst_imem_addr", {16'd0, imem_addr},    32'h0);
    check("rst_out_valid", {31'd0, out_valid},    32'd0);
    check("rst_out_instr", out_instr,             32'h0);
    check("rst_out_pc",    {16'd0, out_pc},       32'h0);
    check("rst_next_pc",   {16'd0, out_next_pc},  32'h4);

    // Streaming from RESET_PC: one instruction every two cycles.
    push_exp(16'h0000); push_exp(16'h0004); push_exp(16'h0008);
    @(negedge clk); #2;
    reset = 1'b1;
    check("idle_no_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk); #2;
    check("req_cycle2", {31'd0, imem_req}, 32'd1);
    wait_buf(16'h0000, 10);
    @(negedge clk); #2;
    check("gap_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); #2;
    check("pc4_at_2cyc", {16'd0, out_pc}, 32'h4);
    @(negedge clk); #2;
    @(negedge clk); #2;
    check("pc8_at_2cyc", {16'd0, out_pc}, 32'h8);

    // Back-pressure: hold the buffer at pc 8.
    out_ready = 1'b0;
    #1;
    check("stall_req_now", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #2;
      check("stall_req",   {31'd0, imem_req},  32'd0);
      check("stall_pc",    {16'd0, out_pc},    32'h8);
      check("stall_instr", out_instr,          instr_of(16'h0008));
      check("stall_addr",  {16'd0, imem_addr}, 32'hC);
    end
    push_exp(16'h000C);
    out_ready = 1'b1;
    #1;
    check("unstall_req", {31'd0, imem_req}, 32'd1);

    // Redirect to 0x40 while waiting; old response arrives 3 cycles after grant.
    wait_buf(16'h000C, 10);
    lat = 3;
    @(negedge clk); #2;
    redirect_valid  = 1'b1;
    redirect_target = 16'h0040;
    @(negedge clk); #2;
    redirect_valid = 1'b0;
    check("discard_req",   {31'd0, imem_req},  32'd0);
    check("discard_valid", {31'd0, out_valid}, 32'd0);
    wait_req(10);
    check("redir_addr_40", {16'd0, imem_addr}, 32'h40);
    lat = 1;
    push_exp(16'h0040);

    // Redirect to 0x23 in the same cycle the response returns.
    wait_buf(16'h0040, 10);
    @(negedge clk); #2;
    check("rvalid_with_redir", {31'd0, imem_rvalid}, 32'd1);
    redirect_valid  = 1'b1;
    redirect_target = 16'h0023;
    @(negedge clk); #2;
    redirect_valid = 1'b0;
    check("redir23_valid", {31'd0, out_valid}, 32'd0);
    check("redir23_addr",  {16'd0, imem_addr}, 32'h20);
    check("redir23_req",   {31'd0, imem_req},  32'd1);
    out_ready = 1'b0;

    // Redirect to the top aligned address while the buffer is full and stalled.
    wait_buf(16'h0020, 10);
    check("held20_instr", out_instr, instr_of(16'h0020));
    check("held20_req",   {31'd0, imem_req}, 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 16'hFFFE;
    @(negedge clk); #2;
    redirect_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("top_addr",    {16'd0, imem_addr}, 32'hFFFC);
    check("top_req",     {31'd0, imem_req},  32'd1);
    push_exp(16'hFFFC);
    push_exp(16'h0000);
    out_ready = 1'b1;
    wait_buf(16'hFFFC, 10);
    check("wrap_addr",    {16'd0, imem_addr},   32'h0);
    check("wrap_next_pc", {16'd0, out_next_pc}, 32'h0);

    // Reset while waiting, then a stray response after release.
    wait_buf(16'h0000, 10);
    lat = 3;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req",   {31'd0, imem_req},    32'd0);
    check("mid_rst_addr",  {16'd0, imem_addr},   32'h0);
    check("mid_rst_valid", {31'd0, out_valid},   32'd0);
    check("mid_rst_instr", out_instr,            32'h0);
    check("mid_rst_pc",    {16'd0, out_pc},      32'h0);
    check("mid_rst_next",  {16'd0, out_next_pc}, 32'h4);
    @(negedge clk); #2;
    reset = 1'b1;
    lat   = 1;
    stray = 1'b1;
    push_exp(16'h0000);
    push_exp(16'h0004);
    @(negedge clk); #2;
    check("stray_rvalid", {31'd0, imem_rvalid}, 32'd1);
    check("restart_req",  {31'd0, imem_req},    32'd1);
    check("restart_addr", {16'd0, imem_addr},   32'h0);
    wait_buf(16'h0000, 10);
    wait_buf(16'h0004, 10);
    imem_gnt = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("final_req_pending", {31'd0, imem_req}, 32'd1);
    check("exp_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
